// File: rtl/exit_status_apb_pkg.sv
// exit_status_apb_pkg: shared types and constants for the end-of-test reporter and its bench interface
package exit_status_apb_pkg;
  typedef enum logic [1:0] {SUCCESS = 2'd0, FAIL = 2'd1, TIMEOUT = 2'd2, RUNNING = 2'd3} exit_status_e;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_e;
  localparam logic [1:0] REG_EXIT = 2'd0;
  localparam logic [1:0] REG_TIMEOUT = 2'd1;
  localparam logic [1:0] REG_DRAIN = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam int TIMEOUT_CODE = 'hFF;
endpackage

// File: rtl/exit_status_apb_cnt.sv
// exit_status_apb_cnt: loadable up/down counter that saturates at both ends
// ports: clk, rst; load/load_val overrides counting; up/dn step q by one, holding at all-ones / zero
module exit_status_apb_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up,
  input  logic         dn,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= load_val;
    else if (up && q != '1) q <= q + 1'b1;
    else if (dn && q != '0) q <= q - 1'b1;
endmodule

// File: rtl/exit_status_apb.sv
// exit_status_apb: APB end-of-test register block with watchdog and drain delay before done
// ports: clk, rst; APB slave (paddr/pwdata/pwrite/psel/penable -> prdata/pready/pslverr, zero wait);
//        done/status/exit_code are the registered end-of-test outputs sampled by the bench
module exit_status_apb
  import exit_status_apb_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter int          CODE_W         = 8,
  parameter logic [31:0] DRAIN_RST      = 32'd16,
  parameter logic [31:0] TIMEOUT_RST    = 32'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]               pwdata,
  input  logic                      pwrite,
  input  logic                      psel,
  input  logic                      penable,
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      done,
  output exit_status_e              status,
  output logic [CODE_W-1:0]         exit_code
);
  state_e       state;
  exit_status_e pend;
  logic [31:0]  timeout_r, drain_r, wdog, dcnt;
  logic [1:0]   addr;
  logic         acc, wr, exit_wr, wdog_hit, unused;
  assign addr     = paddr[3:2];
  assign acc      = psel & penable;
  assign wr       = acc & pwrite;
  assign exit_wr  = wr && addr == REG_EXIT && state == RUN;
  // the compare uses the count before this edge, so expiry lands exactly TIMEOUT cycles after a clear
  assign wdog_hit = state == RUN && timeout_r != '0 && wdog == timeout_r - 32'd1;
  assign pready   = 1'b1;
  assign pslverr  = wr && ((addr == REG_EXIT && state != RUN) || addr == REG_STATUS);
  assign unused   = ^{paddr[APB_ADDR_WIDTH-1:4], paddr[1:0]};
  always_comb
    prdata = !(acc && !pwrite)    ? '0 :
             addr == REG_EXIT     ? {state != RUN, 31'(exit_code)} :
             addr == REG_TIMEOUT  ? timeout_r :
             addr == REG_DRAIN    ? drain_r :
                                    {state, status, wdog[27:0]};
  exit_status_apb_cnt #(.W(32)) u_wdog (
    .clk(clk), .rst(rst), .load(wr && addr == REG_TIMEOUT), .load_val('0),
    .up(state == RUN && timeout_r != '0), .dn(1'b0), .q(wdog)
  );
  // loaded only on entry, so DRAIN writes during the countdown apply to the next run
  exit_status_apb_cnt #(.W(32)) u_drain (
    .clk(clk), .rst(rst), .load(exit_wr | wdog_hit), .load_val(drain_r),
    .up(1'b0), .dn(state == DRAIN), .q(dcnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pend      <= RUNNING;
      status    <= RUNNING;
      done      <= 1'b0;
      exit_code <= '0;
      timeout_r <= TIMEOUT_RST;
      drain_r   <= DRAIN_RST;
    end else begin
      if (wr && addr == REG_TIMEOUT) timeout_r <= pwdata;
      if (wr && addr == REG_DRAIN) drain_r <= pwdata;
      if (exit_wr) begin
        exit_code <= pwdata[CODE_W-1:0];
        pend      <= pwdata[CODE_W-1:0] == '0 ? SUCCESS : FAIL;
        state     <= DRAIN;
      end else if (wdog_hit) begin
        exit_code <= CODE_W'(TIMEOUT_CODE);
        pend      <= TIMEOUT;
        state     <= DRAIN;
      end else if (state == DRAIN && dcnt == '0) begin
        state  <= DONE;
        done   <= 1'b1;
        status <= pend;
      end
    end
  end
endmodule
